// File: rtl/nexys_starship_repair_sched.sv
// nexys_starship_repair_sched
//
// Purpose: shares the single repair input (4 switches committed by a centre
// button pulse) among the four starship rooms. One broken room at a time is
// chosen in round-robin order and given a pseudo-random 4-bit code. A
// matching combo repairs the room. A wrong combo locks the input out for a
// while. Taking too long abandons the room.
//
// Ports:
//   Clk            in   system clock
//   Reset_n        in   synchronous active-low reset
//   play_flag      in   game is in Play
//   game_over      in   game has ended
//   broken[3:0]    in   room broken flags {top, btm, left, right}
//   combo_valid    in   one-cycle pulse, combo committed
//   combo[3:0]     in   switch value
//   active_room    out  one-hot room under repair, 0 when none
//   required_code  out  code the active room expects, 0 when none
//   repair_done    out  one-cycle pulse on the repaired room's bit
//   repair_fail    out  one-cycle pulse on a wrong combo
//   repair_timeout out  one-cycle pulse when the room is abandoned
//   lockout        out  high while wrong-combo lockout is running

module nexys_starship_repair_sched #(
  parameter int         TIMEOUT_CYCLES = 500_000_000,
  parameter int         LOCKOUT_CYCLES = 100_000_000,
  parameter int         CNT_W          = 29,
  parameter logic [3:0] LFSR_SEED      = 4'h1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       play_flag,
  input  logic       game_over,
  input  logic [3:0] broken,
  input  logic       combo_valid,
  input  logic [3:0] combo,
  output logic [3:0] active_room,
  output logic [3:0] required_code,
  output logic [3:0] repair_done,
  output logic       repair_fail,
  output logic       repair_timeout,
  output logic       lockout
);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    WAIT,
    LOCKOUT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCKOUT_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       rr_ptr;
  logic [1:0]       active_idx;
  logic [3:0]       lfsr;

  logic [3:0]       lfsr_next;
  logic             abort;
  logic             active_broken;
  logic             pick_found;
  logic [1:0]       pick_idx;
  logic [1:0]       cand;

  // Taps at bits 3 and 2 give a maximal-length sequence, so a nonzero seed
  // never reaches zero and required_code is never 0.
  assign lfsr_next     = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
  assign abort         = game_over | ~play_flag;
  assign active_broken = broken[active_idx];

  // Round-robin search rr_ptr, rr_ptr-1, ... with wrap. Scanning from the
  // farthest candidate back to rr_ptr lets the nearest set bit win.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr;
    cand       = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr - 2'(k);
      if (broken[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Single state machine; every output is a register. Pulses default low and
  // are raised only on the transition that owns them, so they cannot overlap.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      rr_ptr         <= 2'd3;
      active_idx     <= 2'd0;
      lfsr           <= LFSR_SEED;
      active_room    <= 4'd0;
      required_code  <= 4'd0;
      repair_done    <= 4'd0;
      repair_fail    <= 1'b0;
      repair_timeout <= 1'b0;
      lockout        <= 1'b0;
    end else begin
      repair_done    <= 4'd0;
      repair_fail    <= 1'b0;
      repair_timeout <= 1'b0;

      if (abort) begin
        state         <= IDLE;
        cnt           <= '0;
        active_room   <= 4'd0;
        required_code <= 4'd0;
        lockout       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (|broken) state <= SELECT;
          end

          SELECT: begin
            if (pick_found) begin
              active_idx    <= pick_idx;
              active_room   <= 4'b0001 << pick_idx;
              lfsr          <= lfsr_next;
              required_code <= lfsr_next;
              cnt           <= '0;
              state         <= WAIT;
            end else begin
              state <= IDLE;
            end
          end

          WAIT: begin
            // A room repaired elsewhere is dropped silently; a committed
            // combo outranks a timeout landing on the same cycle.
            if (!active_broken) begin
              active_room   <= 4'd0;
              required_code <= 4'd0;
              cnt           <= '0;
              state         <= IDLE;
            end else if (combo_valid) begin
              if (combo == required_code) begin
                state <= DONE;
              end else begin
                repair_fail <= 1'b1;
                lockout     <= 1'b1;
                cnt         <= '0;
                state       <= LOCKOUT;
              end
            end else if (cnt == TIMEOUT_LAST) begin
              repair_timeout <= 1'b1;
              rr_ptr         <= active_idx - 2'd1;
              active_room    <= 4'd0;
              required_code  <= 4'd0;
              cnt            <= '0;
              state          <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          LOCKOUT: begin
            // combo_valid is deliberately not looked at here.
            if (!active_broken) begin
              active_room   <= 4'd0;
              required_code <= 4'd0;
              lockout       <= 1'b0;
              cnt           <= '0;
              state         <= IDLE;
            end else if (cnt == LOCKOUT_LAST) begin
              lockout <= 1'b0;
              cnt     <= '0;
              state   <= WAIT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          DONE: begin
            repair_done   <= active_room;
            rr_ptr        <= active_idx - 2'd1;
            active_room   <= 4'd0;
            required_code <= 4'd0;
            state         <= IDLE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nexys_starship_repair_sched.sv
// tb_nexys_starship_repair_sched
//
// Directed bench for the repair scheduler with short timeout/lockout windows
// (20 and 5 cycles). Inputs change and outputs are sampled 1 time unit after
// each rising edge. A negedge monitor tallies every pulse so that unexpected
// pulses show up as wrong totals.

module tb_nexys_starship_repair_sched;

  logic       clk;
  logic       reset_n;
  logic       play_flag;
  logic       game_over;
  logic [3:0] broken;
  logic       combo_valid;
  logic [3:0] combo;
  logic [3:0] active_room;
  logic [3:0] required_code;
  logic [3:0] repair_done;
  logic       repair_fail;
  logic       repair_timeout;
  logic       lockout;

  int assertion_count = 0;
  int failure_count   = 0;
  int done_count      = 0;
  int fail_count      = 0;
  int timeout_count   = 0;
  int overlap_count   = 0;

  nexys_starship_repair_sched #(
    .TIMEOUT_CYCLES(20),
    .LOCKOUT_CYCLES(5),
    .CNT_W(8),
    .LFSR_SEED(4'h1)
  ) dut (
    .Clk(clk),
    .Reset_n(reset_n),
    .play_flag(play_flag),
    .game_over(game_over),
    .broken(broken),
    .combo_valid(combo_valid),
    .combo(combo),
    .active_room(active_room),
    .required_code(required_code),
    .repair_done(repair_done),
    .repair_fail(repair_fail),
    .repair_timeout(repair_timeout),
    .lockout(lockout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse tally sampled on the falling edge, away from register updates.
  always @(negedge clk) begin
    int n;
    n = 0;
    if (repair_done !== 4'd0) begin
      done_count++;
      n++;
    end
    if (repair_fail === 1'b1) begin
      fail_count++;
      n++;
    end
    if (repair_timeout === 1'b1) begin
      timeout_count++;
      n++;
    end
    if (n > 1) overlap_count++;
  end

  // Count one comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertion_count++;
    if (observed !== expected) begin
      failure_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic play, input logic over, input logic [3:0] brk,
                               input logic cv, input logic [3:0] cmb);
    play_flag   = play;
    game_over   = over;
    broken      = brk;
    combo_valid = cv;
    combo       = cmb;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] allOutputs();
    return {17'd0, active_room, required_code, repair_done,
            repair_fail, repair_timeout, lockout};
  endfunction

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 4'h0);

    // Reset state
    stepCycles(3);
    checkOutput("reset_outputs", allOutputs(), 32'd0);

    // First grant: top not broken, so bottom (bit 2) with code 2
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'b0110, 1'b0, 4'h0);
    stepCycles(1);
    checkOutput("select_no_grant_yet", active_room, 4'b0000);
    stepCycles(1);
    checkOutput("grant1_room", active_room, 4'b0100);
    checkOutput("grant1_code", required_code, 4'h2);

    // Correct combo: repair_done two cycles after the pulse
    applyStimulus(1'b1, 1'b0, 4'b0110, 1'b1, 4'h2);
    stepCycles(1);
    applyStimulus(1'b1, 1'b0, 4'b0110, 1'b0, 4'h0);
    checkOutput("done_not_early", repair_done, 4'b0000);
    stepCycles(1);
    checkOutput("done_pulse", repair_done, 4'b0100);
    checkOutput("done_room_cleared", active_room, 4'b0000);
    applyStimulus(1'b1, 1'b0, 4'b1010, 1'b0, 4'h0);
    stepCycles(1);
    checkOutput("done_one_cycle", repair_done, 4'b0000);
    stepCycles(1);
    checkOutput("grant2_room", active_room, 4'b0010);
    checkOutput("grant2_code", required_code, 4'h4);

    // Wrong combo: fail pulse, 5 cycles of lockout, ignored correct combo
    applyStimulus(1'b1, 1'b0, 4'b1010, 1'b1, 4'hF);
    stepCycles(1);
    applyStimulus(1'b1, 1'b0, 4'b1010, 1'b0, 4'h0);
    checkOutput("fail_pulse", {31'd0, repair_fail}, 32'd1);
    checkOutput("lockout_0", {31'd0, lockout}, 32'd1);
    for (int i = 1; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 4'b1010, (i == 2), 4'h4);
      stepCycles(1);
      checkOutput($sformatf("lockout_%0d", i), {31'd0, lockout}, 32'd1);
    end
    applyStimulus(1'b1, 1'b0, 4'b1010, 1'b0, 4'h0);
    stepCycles(1);
    checkOutput("lockout_end", {31'd0, lockout}, 32'd0);
    checkOutput("resume_room", active_room, 4'b0010);
    checkOutput("resume_code", required_code, 4'h4);
    checkOutput("lockout_combo_ignored", done_count, 32'd1);

    // Timeout after 20 WAIT cycles; round robin wraps to top with code 9
    stepCycles(19);
    checkOutput("no_timeout_early", {31'd0, repair_timeout}, 32'd0);
    stepCycles(1);
    checkOutput("timeout_pulse", {31'd0, repair_timeout}, 32'd1);
    checkOutput("timeout_room_cleared", active_room, 4'b0000);
    stepCycles(2);
    checkOutput("grant3_room", active_room, 4'b1000);
    checkOutput("grant3_code", required_code, 4'h9);

    // game_over mid-WAIT: room cleared next cycle, no pulse
    stepCycles(2);
    applyStimulus(1'b1, 1'b1, 4'b1010, 1'b0, 4'h0);
    stepCycles(1);
    checkOutput("abort_room", active_room, 4'b0000);
    checkOutput("abort_code", required_code, 4'h0);
    applyStimulus(1'b1, 1'b0, 4'b1010, 1'b0, 4'h0);
    stepCycles(2);
    checkOutput("grant4_room", active_room, 4'b1000);
    checkOutput("grant4_code", required_code, 4'h3);

    // Active room fixed elsewhere during lockout: silent return to IDLE
    applyStimulus(1'b1, 1'b0, 4'b1010, 1'b1, 4'h0);
    stepCycles(1);
    applyStimulus(1'b1, 1'b0, 4'b1010, 1'b0, 4'h0);
    checkOutput("lockout2_on", {31'd0, lockout}, 32'd1);
    stepCycles(1);
    applyStimulus(1'b1, 1'b0, 4'b0010, 1'b0, 4'h0);
    stepCycles(1);
    checkOutput("room_abort_outputs", allOutputs(), 32'd0);
    stepCycles(2);
    checkOutput("grant5_room", active_room, 4'b0010);
    checkOutput("grant5_code", required_code, 4'h6);

    // Correct combo on the very cycle the timeout count is reached
    stepCycles(19);
    applyStimulus(1'b1, 1'b0, 4'b0010, 1'b1, 4'h6);
    stepCycles(1);
    applyStimulus(1'b1, 1'b0, 4'b0010, 1'b0, 4'h0);
    checkOutput("race_no_timeout", {31'd0, repair_timeout}, 32'd0);
    stepCycles(1);
    checkOutput("race_done", repair_done, 4'b0010);
    checkOutput("race_no_timeout2", {31'd0, repair_timeout}, 32'd0);
    stepCycles(2);
    checkOutput("grant6_room", active_room, 4'b0010);
    checkOutput("grant6_code", required_code, 4'hD);

    // Reset during lockout, then LFSR restarts from the seed
    applyStimulus(1'b1, 1'b0, 4'b0010, 1'b1, 4'h0);
    stepCycles(1);
    applyStimulus(1'b1, 1'b0, 4'b0010, 1'b0, 4'h0);
    checkOutput("lockout3_on", {31'd0, lockout}, 32'd1);
    stepCycles(1);
    reset_n = 1'b0;
    stepCycles(1);
    checkOutput("midreset_outputs", allOutputs(), 32'd0);
    reset_n = 1'b1;
    stepCycles(2);
    checkOutput("grant7_room", active_room, 4'b0010);
    checkOutput("grant7_code", required_code, 4'h2);

    // Pulse totals over the whole run
    stepCycles(1);
    checkOutput("total_done", done_count, 32'd2);
    checkOutput("total_fail", fail_count, 32'd3);
    checkOutput("total_timeout", timeout_count, 32'd1);
    checkOutput("pulse_overlap", overlap_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertion_count, failure_count);
    $finish;
  end

endmodule
